// File: rtl/input_conditioner.sv
// Per-bit 2-flop synchroniser, debounce counter and registered edge pulses
// for raw buttons and switches, all in the single CLK domain.
module input_conditioner #(
  parameter int NBTN            = 4,
  parameter int NSW             = 8,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [NSW-1:0]  sw_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NSW-1:0]  sw_level,
  output logic [NSW-1:0]  sw_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int NCH   = NBTN + NSW;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Buttons occupy the low channel indices, switches the high ones.
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;
  logic [CNT_W-1:0] cnt [NCH];

  assign raw = {sw_raw, btn_raw};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          // Level and pulse change on the same edge.
          stable[i] <= s2[i];
          rise[i]   <= s2[i];
          fall[i]   <= ~s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level   = stable[NBTN-1:0];
  assign btn_press   = rise[NBTN-1:0];
  assign btn_release = fall[NBTN-1:0];
  assign sw_level    = stable[NCH-1:NBTN];
  assign sw_change   = rise[NCH-1:NBTN] | fall[NCH-1:NBTN];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

  localparam int NBTN = 4;
  localparam int NSW  = 8;
  localparam int DC   = 4;
  localparam int LAT  = DC + 2;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [NBTN-1:0] btn_raw;
  logic [NSW-1:0]  sw_raw;
  logic [NBTN-1:0] btn_level, btn_press, btn_release;
  logic [NSW-1:0]  sw_level, sw_change;

  input_conditioner #(
    .NBTN(NBTN),
    .NSW(NSW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .btn_raw(btn_raw),
    .sw_raw(sw_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .sw_level(sw_level),
    .sw_change(sw_change)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int unsigned     cyc;
    logic [NBTN-1:0] bl;
    logic [NBTN-1:0] bp;
    logic [NBTN-1:0] br;
    logic [NSW-1:0]  sl;
    logic [NSW-1:0]  sc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_event(input int unsigned at, input logic [NBTN-1:0] bl,
                              input logic [NBTN-1:0] bp, input logic [NBTN-1:0] br,
                              input logic [NSW-1:0] sl, input logic [NSW-1:0] sc);
    exp_t e;
    e.cyc = at; e.bl = bl; e.bp = bp; e.br = br; e.sl = sl; e.sc = sc;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the next queued event in time and content.
  always @(negedge CLK) begin
    if ((btn_press | btn_release) != '0 || sw_change != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {btn_press, btn_release, sw_change}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("btn_level", 32'(btn_level), 32'(e.bl));
        check("btn_press", 32'(btn_press), 32'(e.bp));
        check("btn_release", 32'(btn_release), 32'(e.br));
        check("sw_level", 32'(sw_level), 32'(e.sl));
        check("sw_change", 32'(sw_change), 32'(e.sc));
      end
    end
  end

  initial begin
    RST_N   = 1'b0;
    btn_raw = '0;
    sw_raw  = '0;
    tick(3);
    check("reset_outputs", {btn_level, btn_press, btn_release, sw_level, sw_change}, 32'h0);
    RST_N = 1'b1;

    tick(20);
    check("idle_levels", {btn_level, sw_level}, 32'h0);

    // Single clean press on btn 0.
    btn_raw[0] = 1'b1;
    expect_event(cyc + LAT, 4'b0001, 4'b0001, 4'b0000, 8'h00, 8'h00);
    tick(12);

    // Bounce on btn 1: only the final rise survives.
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1; tick(2);
    btn_raw[1] = 1'b0; tick(2);
    btn_raw[1] = 1'b1;
    expect_event(cyc + LAT, 4'b0011, 4'b0010, 4'b0000, 8'h00, 8'h00);
    tick(12);

    // Multi-bit switch change in both directions.
    sw_raw = 8'hA5;
    expect_event(cyc + LAT, 4'b0011, 4'b0000, 4'b0000, 8'hA5, 8'hA5);
    tick(12);
    sw_raw = 8'h00;
    expect_event(cyc + LAT, 4'b0011, 4'b0000, 4'b0000, 8'h00, 8'hA5);
    tick(12);

    // btn 2 pressed, reset lands when its count has reached 2.
    btn_raw[2] = 1'b1;
    tick(4);
    RST_N = 1'b0;
    tick(1);
    check("midreset_outputs", {btn_level, btn_press, btn_release, sw_level, sw_change}, 32'h0);
    RST_N = 1'b1;
    // Buttons 0..2 are all still held, so all re-press together.
    expect_event(cyc + LAT, 4'b0111, 4'b0111, 4'b0000, 8'h00, 8'h00);
    tick(12);

    // Release btn 0.
    btn_raw[0] = 1'b0;
    expect_event(cyc + LAT, 4'b0110, 4'b0000, 4'b0001, 8'h00, 8'h00);
    tick(12);

    check("final_btn_level", 32'(btn_level), 32'h6);
    check("final_sw_level", 32'(sw_level), 32'h0);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises, debounces and edge-detects the board's raw push-buttons and slide switches so downstream logic sees clean levels and one-cycle event pulses on CLK. It replaces button-edge clocking (e.g. registering on a button's falling edge) with events in the single CLK domain. It sits between the top-level pins and the arithmetic/display datapath, which feeds the seven-segment mux.

## Interface
- NBTN, 4 — number of button inputs
- NSW, 8 — number of switch inputs
- DEBOUNCE_CYCLES, 120000 — consecutive stable CLK cycles needed to accept a change; 10 ms at 12 MHz; legal range ≥2
- CNT_W, $clog2(DEBOUNCE_CYCLES) — debounce counter width (localparam)

Ports:
- CLK  in  1  system clock; all state on rising edge
- RST_N  in  1  synchronous reset, active-low
- btn_raw  in  NBTN  raw button pins, active-high (active-low pins such as BTN_N are inverted by the instantiator)
- sw_raw  in  NSW  raw switch pins
- btn_level  out  NBTN  debounced button state
- btn_press  out  NBTN  one-cycle pulse on accepted 0→1
- btn_release  out  NBTN  one-cycle pulse on accepted 1→0
- sw_level  out  NSW  debounced switch state
- sw_change  out  NSW  one-cycle pulse on any accepted switch transition

## Operation
- Per input bit (NBTN+NSW independent channels), identical logic:
  - 2-flop synchroniser: s1 <= raw, s2 <= s1.
  - stable register (drives *_level) and counter cnt[CNT_W-1:0].
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, event pulse asserted.
- Any bounce (s2 returning to stable) before the count completes clears cnt; the count restarts from 0 on the next difference.
- Pulses are registered, asserted in the same cycle the new level first appears, and deasserted the next cycle unless another accepted change occurs there (impossible with DEBOUNCE_CYCLES ≥ 2).
- btn_press = accepted rising change; btn_release = accepted falling change; sw_change = either direction.
- Channels never interact; simultaneous changes on several bits each produce their own pulse in the same cycle.
- Counter saturation is impossible: cnt never exceeds DEBOUNCE_CYCLES-1.

## Timing
- Reset (RST_N low at a rising edge): s1, s2, stable, cnt and all pulse outputs cleared to 0. All outputs are 0 the cycle after reset.
- Reset mid-count discards the count; no pulse is produced.
- Latency: raw change at or before edge 1, then held → s2 updates at edge 2, level + pulse update at edge DEBOUNCE_CYCLES+2.
- Input held high through reset release: it is treated as a new press; level and btn_press assert DEBOUNCE_CYCLES+2 edges after the first edge with RST_N high.
- Minimum accepted pulse width on raw: DEBOUNCE_CYCLES cycles as seen at s2. Shorter glitches are fully rejected.
- Maximum event rate per channel: one per DEBOUNCE_CYCLES cycles.

## Test plan
Sim with DEBOUNCE_CYCLES=4.
- Reset then idle, all raw 0 → all outputs 0 for 20 cycles, no pulses.
- btn_raw[0] 0→1 at edge 1, held → btn_level[0]=1 and btn_press[0]=1 exactly at edge 6; btn_press[0]=0 at edge 7; btn_release is never asserted.
- Bounce: btn_raw[1] toggles 1,0,1,0 with each value held 2 cycles, then stays 1 → one btn_press[1] only, 6 edges after the final 0→1; the glitches produce no output.
- sw_raw 0x00→0xA5 in one cycle, held → sw_level=0xA5 at the same edge, with sw_change=0xA5 for exactly one cycle. Then 0xA5→0x00 → sw_change=0xA5 again and sw_level=0x00.
- Reset mid-count: raw button held, RST_N pulsed low at count 2 → no pulse; after release, btn_press fires 6 edges after RST_N returns high.
- Release: a held button goes to 0 → btn_release=1 for one cycle, btn_level=0, both 6 edges after the raw change.
